// File: rtl/threshold_scan_sequencer_if.sv
// Command-bus, DAC and counter handshake signals of the threshold scan sequencer.
// The master side is the host/peripheral side; the sequencer uses the slave modport.
interface threshold_scan_sequencer_if;
  logic [7:0]  addr;
  logic [7:0]  data;
  logic        write;
  logic [7:0]  data_out;
  logic        dac_load;
  logic [1:0]  dac_chn;
  logic [11:0] dac_code;
  logic        dac_busy;
  logic        count_start;
  logic        count_done;
  logic [7:0]  step_index;
  logic        scan_busy;
  logic        scan_done;

  modport master (
    output addr, data, write, dac_busy, count_done,
    input  data_out, dac_load, dac_chn, dac_code, count_start, step_index, scan_busy, scan_done
  );

  modport slave (
    input  addr, data, write, dac_busy, count_done,
    output data_out, dac_load, dac_chn, dac_code, count_start, step_index, scan_busy, scan_done
  );
endinterface

// File: rtl/threshold_scan_sequencer.sv
// Autonomous DAC threshold scan: per step load a code, wait for the DAC, settle,
// then run one counter window; an 8-byte register window configures and reports it.
module threshold_scan_sequencer #(
  parameter int unsigned CLK_FREQ     = 50000000,
  parameter logic [7:0]  ADDR_BASE    = 8'h40,
  parameter logic [31:0] MEAS_TIMEOUT = 32'd100000000
) (
  input logic                        clk,
  input logic                        reset,
  threshold_scan_sequencer_if.slave  bus
);
  localparam logic [31:0] CYC_PER_US = 32'(CLK_FREQ / 1000000);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT_DAC, S_SETTLE, S_MEASURE, S_NEXT, S_DONE
  } state_t;

  state_t      state;
  logic [7:0]  rel;
  logic [2:0]  off;
  logic        in_win, wr_en, ctrl_wr, start_req, abort_req;

  logic [1:0]  chn_r;
  logic [7:0]  code_lo_r, step_r, steps_r, settle_r;
  logic [3:0]  code_hi_r;

  logic [7:0]  sh_step, sh_last;
  logic [31:0] sh_settle_cyc, wait_cnt;
  logic        first_q;

  logic [11:0] code_q;
  logic [1:0]  chn_q;
  logic [7:0]  idx_q;
  logic        load_q, cs_q, done_p, busy_q, done_q, err_q;
  logic [12:0] code_sum;
  logic [11:0] next_code;
  logic [7:0]  rdata;

  assign rel       = bus.addr - ADDR_BASE;
  assign in_win    = (rel[7:3] == 5'd0);
  assign off       = rel[2:0];
  assign wr_en     = bus.write && in_win;
  assign ctrl_wr   = wr_en && (off == 3'd0);
  assign abort_req = ctrl_wr && bus.data[1];
  assign start_req = ctrl_wr && bus.data[0] && !bus.data[1];

  assign code_sum  = {1'b0, code_q} + {5'b0, sh_step};
  assign next_code = code_sum[12] ? 12'hFFF : code_sum[11:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chn_r     <= 2'd0;
      code_lo_r <= 8'd0;
      code_hi_r <= 4'd0;
      step_r    <= 8'd0;
      steps_r   <= 8'd1;
      settle_r  <= 8'd10;
    end else if (wr_en) begin
      case (off)
        3'd0:    chn_r     <= bus.data[3:2];
        3'd1:    code_lo_r <= bus.data;
        3'd2:    code_hi_r <= bus.data[3:0];
        3'd3:    step_r    <= bus.data;
        3'd4:    steps_r   <= bus.data;
        3'd5:    settle_r  <= bus.data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      sh_step       <= 8'd0;
      sh_last       <= 8'd0;
      sh_settle_cyc <= 32'd0;
      wait_cnt      <= 32'd0;
      first_q       <= 1'b0;
      code_q        <= 12'd0;
      chn_q         <= 2'd0;
      idx_q         <= 8'd0;
      load_q        <= 1'b0;
      cs_q          <= 1'b0;
      done_p        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      load_q <= 1'b0;
      cs_q   <= 1'b0;
      done_p <= 1'b0;
      if (abort_req) begin
        state  <= S_IDLE;
        busy_q <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (start_req) begin
            sh_step       <= step_r;
            sh_last       <= (steps_r == 8'd0) ? 8'd0 : steps_r - 8'd1;
            sh_settle_cyc <= 32'(settle_r) * CYC_PER_US;
            code_q        <= {code_hi_r, code_lo_r};
            chn_q         <= bus.data[3:2];
            idx_q         <= 8'd0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            busy_q        <= 1'b1;
            load_q        <= 1'b1;
            state         <= S_LOAD;
          end
          S_LOAD: begin
            first_q <= 1'b1;
            state   <= S_WAIT_DAC;
          end
          S_WAIT_DAC: begin
            // dac_busy may still be low right after the load, so ignore the first cycle
            if (first_q) first_q <= 1'b0;
            else if (!bus.dac_busy) begin
              wait_cnt <= sh_settle_cyc;
              state    <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            // the cycle dac_busy is seen low is the first settle cycle; at least one cycle here
            if (wait_cnt <= 32'd2) begin
              wait_cnt <= 32'd0;
              cs_q     <= 1'b1;
              state    <= S_MEASURE;
            end else wait_cnt <= wait_cnt - 32'd1;
          end
          S_MEASURE: begin
            if (bus.count_done && !cs_q) state <= S_NEXT;
            else if (wait_cnt == MEAS_TIMEOUT - 32'd1) begin
              err_q  <= 1'b1;
              busy_q <= 1'b0;
              state  <= S_IDLE;
            end else wait_cnt <= wait_cnt + 32'd1;
          end
          S_NEXT: begin
            if (idx_q == sh_last) begin
              done_p <= 1'b1;
              done_q <= 1'b1;
              state  <= S_DONE;
            end else begin
              idx_q  <= idx_q + 8'd1;
              code_q <= next_code;
              load_q <= 1'b1;
              state  <= S_LOAD;
            end
          end
          S_DONE: begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    rdata = 8'h00;
    if (in_win) begin
      case (off)
        3'd0: rdata = {4'b0, chn_r, 2'b00};
        3'd1: rdata = code_lo_r;
        3'd2: rdata = {4'b0, code_hi_r};
        3'd3: rdata = step_r;
        3'd4: rdata = steps_r;
        3'd5: rdata = settle_r;
        3'd6: rdata = {busy_q, done_q, err_q, 5'b0};
        3'd7: rdata = idx_q;
        default: rdata = 8'h00;
      endcase
    end
  end

  assign bus.data_out    = rdata;
  assign bus.dac_load    = load_q;
  assign bus.dac_chn     = chn_q;
  assign bus.dac_code    = code_q;
  assign bus.count_start = cs_q;
  assign bus.step_index  = idx_q;
  assign bus.scan_busy   = busy_q;
  assign bus.scan_done   = done_p;
endmodule

// File: tb/tb_threshold_scan_sequencer.sv
// Scoreboard bench: expected DAC loads, window starts and completions are queued
// per scan; a negedge monitor pops and compares on every DUT pulse.
module tb_threshold_scan_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  threshold_scan_sequencer_if bus();

  threshold_scan_sequencer #(.MEAS_TIMEOUT(32'd1000)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  typedef struct { logic [1:0] chn; logic [11:0] code; } load_t;
  load_t exp_load[$];
  int    exp_cs[$];
  int    exp_done[$];

  int errors = 0, checks = 0;
  int cyc = 0;
  int load_cyc = 0, cs_cyc = 0, fall_cyc = 0;
  int n_load = 0, n_cs = 0, n_done = 0;
  int busy_len = 2;
  int cnt_en = 1;
  int bcnt = 0, ccnt = 0;
  logic dbusy = 1'b0, cdone = 1'b0;

  assign bus.dac_busy   = dbusy;
  assign bus.count_done = cdone;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL unexpected_%s: pulse with empty queue (cycle %0d)", name, cyc);
  endtask

  // DAC model: busy for busy_len sampled cycles after each load
  always @(negedge clk) begin
    if (reset) begin
      bcnt = 0; dbusy = 1'b0;
    end else begin
      if (bus.dac_load) bcnt = busy_len;
      else if (bcnt > 0) bcnt--;
      if (dbusy && bcnt == 0) fall_cyc = cyc;
      dbusy = (bcnt > 0);
    end
  end

  // Counter model: count_done 5 cycles after count_start
  always @(negedge clk) begin
    if (reset) begin
      ccnt = 0; cdone = 1'b0;
    end else begin
      cdone = 1'b0;
      if (ccnt > 0) begin
        ccnt--;
        if (ccnt == 0) cdone = 1'b1;
      end
      if (bus.count_start && cnt_en != 0) ccnt = 5;
    end
  end

  always @(negedge clk) begin
    load_t e;
    if (!reset) begin
      if (bus.dac_load) begin
        load_cyc = cyc; n_load++;
        if (exp_load.size() == 0) unexpected("dac_load");
        else begin
          e = exp_load.pop_front();
          check("load_code", 32'(bus.dac_code), 32'(e.code));
          check("load_chn", 32'(bus.dac_chn), 32'(e.chn));
        end
      end
      if (bus.count_start) begin
        cs_cyc = cyc; n_cs++;
        if (exp_cs.size() == 0) unexpected("count_start");
        else check("cs_step", 32'(bus.step_index), 32'(exp_cs.pop_front()));
      end
      if (bus.scan_done) begin
        n_done++;
        if (exp_done.size() == 0) unexpected("scan_done");
        else check("done_step", 32'(bus.step_index), 32'(exp_done.pop_front()));
      end
    end
  end

  // All bus tasks are entered and left at a negedge.
  task automatic wr(input logic [2:0] o, input logic [7:0] d);
    bus.addr = 8'h40 + {5'd0, o}; bus.data = d; bus.write = 1'b1;
    @(negedge clk);
    bus.write = 1'b0; bus.addr = 8'h00; bus.data = 8'h00;
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
    bus.addr = a;
    #1 check(name, 32'(bus.data_out), 32'(exp));
  endtask

  task automatic wait_idle(input int maxc, output int at);
    int k;
    for (k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (!bus.scan_busy) break;
    end
    at = cyc;
    if (k == maxc) begin
      checks++; errors++;
      $display("FAIL wait_idle: scan_busy still high after %0d cycles", maxc);
    end
  endtask

  task automatic clr_counts();
    n_load = 0; n_cs = 0; n_done = 0;
  endtask

  task automatic drain_chk(input string name);
    check({name, "_load_q"}, 32'(exp_load.size()), 0);
    check({name, "_cs_q"}, 32'(exp_cs.size()), 0);
    check({name, "_done_q"}, 32'(exp_done.size()), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t_idle;
    logic [11:0] c;
    reset = 1'b1;
    bus.addr = 8'h00; bus.data = 8'h00; bus.write = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_code", 32'(bus.dac_code), 0);
    check("rst_busy", 32'(bus.scan_busy), 0);
    check("rst_idx", 32'(bus.step_index), 0);
    rd_chk("rst_steps", 8'h44, 8'd1);
    rd_chk("rst_settle", 8'h45, 8'd10);
    rd_chk("rst_status", 8'h46, 8'h00);
    rd_chk("out_of_window_hi", 8'h48, 8'h00);
    rd_chk("out_of_window_lo", 8'h3F, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 1: basic 4-step scan on channel 2, plus ignored restart/config during scan
    wr(3'd1, 8'h00); wr(3'd2, 8'h01); wr(3'd3, 8'h10); wr(3'd4, 8'd4); wr(3'd5, 8'd0);
    busy_len = 2; clr_counts();
    c = 12'h100;
    for (int i = 0; i < 4; i++) begin
      exp_load.push_back('{chn: 2'd2, code: c});
      exp_cs.push_back(i);
      c = c + 12'h010;
    end
    exp_done.push_back(3);
    wr(3'd0, 8'h09);
    repeat (3) @(negedge clk);
    wr(3'd1, 8'h55);
    wr(3'd0, 8'h09);
    wait_idle(500, t_idle);
    check("t1_loads", n_load, 4);
    check("t1_starts", n_cs, 4);
    check("t1_dones", n_done, 1);
    rd_chk("t1_status", 8'h46, 8'h40);
    rd_chk("t1_idx", 8'h47, 8'd3);
    rd_chk("t1_codelo", 8'h41, 8'h55);
    rd_chk("t1_ctrl", 8'h40, 8'h08);
    drain_chk("t1");

    // 2: saturation at 12'hFFF on channel 1
    wr(3'd1, 8'hF0); wr(3'd2, 8'h0F); wr(3'd3, 8'h20); wr(3'd4, 8'd3);
    clr_counts();
    exp_load.push_back('{chn: 2'd1, code: 12'hFF0});
    exp_load.push_back('{chn: 2'd1, code: 12'hFFF});
    exp_load.push_back('{chn: 2'd1, code: 12'hFFF});
    for (int i = 0; i < 3; i++) exp_cs.push_back(i);
    exp_done.push_back(2);
    wr(3'd0, 8'h05);
    wait_idle(500, t_idle);
    check("t2_dones", n_done, 1);
    rd_chk("t2_status", 8'h46, 8'h40);
    drain_chk("t2");

    // 3: settle of 2 us with the DAC busy for 7 cycles
    wr(3'd1, 8'h00); wr(3'd2, 8'h02); wr(3'd4, 8'd1); wr(3'd5, 8'd2);
    busy_len = 7; clr_counts();
    exp_load.push_back('{chn: 2'd0, code: 12'h200});
    exp_cs.push_back(0);
    exp_done.push_back(0);
    wr(3'd0, 8'h01);
    wait_idle(600, t_idle);
    check("t3_settle_gap", cs_cyc - fall_cyc, 100);
    check("t3_load_to_start", cs_cyc - load_cyc, 107);
    drain_chk("t3");

    // 4: abort while step 2 is measuring
    busy_len = 2;
    wr(3'd5, 8'd0); wr(3'd4, 8'd4); wr(3'd1, 8'h00); wr(3'd2, 8'h03); wr(3'd3, 8'h01);
    clr_counts();
    for (int i = 0; i < 3; i++) begin
      exp_load.push_back('{chn: 2'd0, code: 12'h300 + 12'(i)});
      exp_cs.push_back(i);
    end
    wr(3'd0, 8'h01);
    begin
      int k;
      for (k = 0; k < 300; k++) begin
        @(negedge clk);
        if (bus.count_start && bus.step_index == 8'd2) break;
      end
      if (k == 300) begin
        checks++; errors++;
        $display("FAIL t4_find_step2: no count_start for step 2 within 300 cycles");
      end
    end
    wr(3'd0, 8'h02);
    check("t4_busy_after_abort", 32'(bus.scan_busy), 0);
    repeat (30) @(negedge clk);
    check("t4_loads", n_load, 3);
    check("t4_starts", n_cs, 3);
    check("t4_dones", n_done, 0);
    rd_chk("t4_status", 8'h46, 8'h00);
    rd_chk("t4_idx", 8'h47, 8'd2);
    drain_chk("t4");

    // 5: count_done never arrives, measurement times out
    cnt_en = 0;
    wr(3'd4, 8'd2); wr(3'd1, 8'h10); wr(3'd2, 8'h00);
    clr_counts();
    exp_load.push_back('{chn: 2'd0, code: 12'h010});
    exp_cs.push_back(0);
    wr(3'd0, 8'h01);
    wait_idle(1300, t_idle);
    check("t5_timeout_len", t_idle - cs_cyc, 1000);
    check("t5_dones", n_done, 0);
    rd_chk("t5_status", 8'h46, 8'h20);
    drain_chk("t5");
    cnt_en = 1;

    // 6: reset in the middle of settling, then a default scan
    wr(3'd5, 8'd10); wr(3'd4, 8'd1); wr(3'd1, 8'h23); wr(3'd2, 8'h01);
    clr_counts();
    exp_load.push_back('{chn: 2'd3, code: 12'h123});
    wr(3'd0, 8'h0D);
    repeat (30) @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6_code", 32'(bus.dac_code), 0);
    check("t6_chn", 32'(bus.dac_chn), 0);
    check("t6_busy", 32'(bus.scan_busy), 0);
    rd_chk("t6_steps", 8'h44, 8'd1);
    rd_chk("t6_settle", 8'h45, 8'd10);
    rd_chk("t6_codelo", 8'h41, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    clr_counts();
    exp_load.push_back('{chn: 2'd0, code: 12'h000});
    exp_cs.push_back(0);
    exp_done.push_back(0);
    wr(3'd0, 8'h01);
    wait_idle(800, t_idle);
    check("t6_dones", n_done, 1);
    rd_chk("t6_status", 8'h46, 8'h40);
    drain_chk("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
